// File: rtl/ca_row_renderer.sv
// Elementary cellular-automaton line renderer: shows one generation per visible line
// and computes the next generation into the other bank on the fly.
module ca_row_renderer #(
  parameter int unsigned WIDTH    = 1280,
  parameter int unsigned HEIGHT   = 1024,
  parameter int unsigned SEED_POS = 640,
  parameter int unsigned AW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inPrefetchArea,
  input  logic [AW-1:0] prefetchCounterX,
  input  logic [AW-1:0] counterY,
  input  logic [7:0]    rule,
  output logic          ca_pixel,
  output logic          row_done,
  output logic [7:0]    rule_active
);

  localparam int unsigned LAST_X = WIDTH - 1;

  logic          line_act_c;
  logic          first_c;
  logic          cell_c;
  logic          tail_c;
  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic          wr_data_c;

  logic          v1_q;
  logic          v2_q;
  logic          y0_q;
  logic [AW-1:0] x1_q;
  logic [AW-1:0] x2_q;
  logic [2:0]    win_q;
  logic          bank_q;
  logic          rd_q;
  logic          ca_pixel_q;
  logic          row_done_q;
  logic [7:0]    rule_q;

  logic          mem0 [WIDTH];
  logic          mem1 [WIDTH];

  // Pipeline control, generation-0 synthesis and next-row write selection
  always_comb begin
    line_act_c = inPrefetchArea && (counterY < AW'(HEIGHT));
    first_c    = line_act_c && !v1_q;
    cell_c     = y0_q ? (x1_q == AW'(SEED_POS)) : rd_q;
    tail_c     = v2_q && !v1_q;
    wr_en_c    = 1'b0;
    wr_addr_c  = '0;
    wr_data_c  = rule_q[win_q];
    if (row_done_q) begin
      wr_en_c   = 1'b1;
      wr_addr_c = AW'(LAST_X);
    end else if (v2_q && (x2_q != '0)) begin
      wr_en_c   = 1'b1;
      wr_addr_c = x2_q - AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      y0_q       <= 1'b0;
      x1_q       <= '0;
      x2_q       <= '0;
      win_q      <= '0;
      bank_q     <= 1'b0;
      ca_pixel_q <= 1'b0;
      row_done_q <= 1'b0;
      rule_q     <= '0;
    end else begin
      v1_q <= line_act_c;
      if (line_act_c) begin
        x1_q <= prefetchCounterX;
        y0_q <= (counterY == '0);
      end
      v2_q       <= v1_q;
      x2_q       <= x1_q;
      ca_pixel_q <= v1_q && cell_c;
      // Tail cycle shifts in the null right neighbour; flush write follows it
      row_done_q <= tail_c;
      if (first_c) begin
        win_q <= '0;
      end else if (v1_q) begin
        win_q <= {win_q[1:0], cell_c};
      end else if (tail_c) begin
        win_q <= {win_q[1:0], 1'b0};
      end
      if (first_c && (counterY == '0)) begin
        rule_q <= rule;
      end
      if (row_done_q) begin
        bank_q <= ~bank_q;
      end
    end
  end

  // Line banks: contents are not reset; generation 0 never reads them
  always_ff @(posedge clk) begin
    if (line_act_c) begin
      rd_q <= bank_q ? mem1[prefetchCounterX] : mem0[prefetchCounterX];
    end
    if (wr_en_c) begin
      if (bank_q) begin
        mem0[wr_addr_c] <= wr_data_c;
      end else begin
        mem1[wr_addr_c] <= wr_data_c;
      end
    end
  end

  assign ca_pixel    = ca_pixel_q;
  assign row_done    = row_done_q;
  assign rule_active = rule_q;

endmodule

// File: tb/tb_ca_row_renderer.sv
// Scoreboard bench for ca_row_renderer on a reduced raster (24 x 8, seed at 12).
module tb_ca_row_renderer;

  localparam int unsigned W  = 24;
  localparam int unsigned H  = 8;
  localparam int unsigned SP = 12;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inPrefetchArea;
  logic [AW-1:0] prefetchCounterX;
  logic [AW-1:0] counterY;
  logic [7:0]    rule;
  logic          ca_pixel;
  logic          row_done;
  logic [7:0]    rule_active;

  typedef struct {
    logic pix;
    logic rd;
    int   y;
    int   x;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rd_cnt   = 0;

  ca_row_renderer #(.WIDTH(W), .HEIGHT(H), .SEED_POS(SP), .AW(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inPrefetchArea   (inPrefetchArea),
    .prefetchCounterX (prefetchCounterX),
    .counterY         (counterY),
    .rule             (rule),
    .ca_pixel         (ca_pixel),
    .row_done         (row_done),
    .rule_active      (rule_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the entry due now (2 cycles old), then drive and enqueue
  task automatic step(input logic pf, input int x, input int y, input logic ep, input logic er);
    exp_t e;
    exp_t n;
    @(negedge clk);
    if (row_done === 1'b1) rd_cnt++;
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      chk($sformatf("ca_pixel y%0d x%0d", e.y, e.x), 8'(ca_pixel), 8'(e.pix));
      chk($sformatf("row_done y%0d x%0d", e.y, e.x), 8'(row_done), 8'(e.rd));
    end
    inPrefetchArea   = pf;
    prefetchCounterX = AW'(x);
    counterY         = AW'(y);
    n.pix = ep;
    n.rd  = er;
    n.y   = y;
    n.x   = pf ? x : -1;
    sbq.push_back(n);
  endtask

  function automatic logic [W-1:0] next_gen(input logic [W-1:0] c, input logic [7:0] r);
    logic [W-1:0] n;
    logic [2:0]   idx;
    for (int i = 0; i < int'(W); i++) begin
      idx[2] = (i == 0) ? 1'b0 : c[i-1];
      idx[1] = c[i];
      idx[0] = (i == int'(W) - 1) ? 1'b0 : c[i+1];
      n[i]   = r[idx];
    end
    return n;
  endfunction

  task automatic run_line(input int y, input logic [W-1:0] row);
    logic vis;
    vis = (y < int'(H));
    for (int i = 0; i < 2; i++) step(1'b0, 0, y, 1'b0, 1'b0);
    for (int x = 0; x < int'(W); x++) step(1'b1, x, y, vis ? row[x] : 1'b0, 1'b0);
    step(1'b0, 0, y, 1'b0, vis);
    for (int i = 0; i < 3; i++) step(1'b0, 0, y, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] r0, input int chg_y, input logic [7:0] r1);
    logic [W-1:0] g;
    int           base;
    g       = '0;
    g[SP]   = 1'b1;
    rule    = r0;
    base    = rd_cnt;
    for (int y = 0; y < int'(H); y++) begin
      if (y == chg_y) rule = r1;
      run_line(y, g);
      chk($sformatf("rule_active y%0d", y), rule_active, r0);
      g = next_gen(g, r0);
    end
    run_line(int'(H), '0);
    run_line(int'(H) + 1, '0);
    chk("row_done count", 8'(rd_cnt - base), 8'(H));
  endtask

  initial begin
    logic [W-1:0] g;
    rst_n            = 1'b0;
    inPrefetchArea   = 1'b0;
    prefetchCounterX = '0;
    counterY         = '0;
    rule             = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset ca_pixel", 8'(ca_pixel), 8'd0);
    chk("reset row_done", 8'(row_done), 8'd0);
    chk("reset rule_active", rule_active, 8'd0);
    rst_n = 1'b1;

    run_frame(8'd90, -1, 8'd0);
    run_frame(8'd0, -1, 8'd0);
    run_frame(8'd1, -1, 8'd0);
    run_frame(8'd30, 5, 8'd0);
    run_frame(8'd0, -1, 8'd0);

    // Reset in the middle of a visible line
    g     = '0;
    g[SP] = 1'b1;
    rule  = 8'd110;
    for (int y = 0; y < 3; y++) begin
      run_line(y, g);
      g = next_gen(g, 8'd110);
    end
    for (int i = 0; i < 2; i++) step(1'b0, 0, 3, 1'b0, 1'b0);
    for (int x = 0; x <= 15; x++) step(1'b1, x, 3, g[x], 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort ca_pixel", 8'(ca_pixel), 8'd0);
    chk("abort row_done", 8'(row_done), 8'd0);
    chk("abort rule_active", rule_active, 8'd0);
    sbq.delete();
    @(negedge clk);
    inPrefetchArea = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 0, 3, 1'b0, 1'b0);
    run_frame(8'd110, -1, 8'd0);

    for (int i = 0; i < 3; i++) step(1'b0, 0, int'(H) + 2, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
